imem_arbiter: RTL

Sequencing and arbitration controller in front of the instruction cache memory. Shares the icache's single request port between the core fetch stage (read only) and the boot loader/debug port (read/write). After reset, a BOOT phase gives the loader exclusive access to write the program image. In RUN, fetch has priority, with starvation-bounded access for the loader. A debug HALT phase returns exclusive access to the loader.

---
 rtl/imem_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the icache request port between core fetch (read only) and the boot loader/debug port (read/write)
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_boot_done, i_halt              phase controls (levels)
//   i_f_req/i_f_addr                 fetch request; o_f_gnt accept, o_f_rvalid/o_f_rdata response
//   i_l_req/i_l_rnw/i_l_addr/i_l_wdata  loader request; o_l_gnt accept, o_l_rvalid/o_l_rdata response
//   o_mem_rq/o_rnw/o_pc/o_data       icache request port, i_mem_data combinational read data
//   o_state                          BOOT=00, RUN=01, HALT=10
module imem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_boot_done,
    input  logic             i_halt,
    input  logic             i_f_req,
    input  logic [WIDTH-1:0] i_f_addr,
    output logic             o_f_gnt,
    output logic             o_f_rvalid,
    output logic [WIDTH-1:0] o_f_rdata,
    input  logic             i_l_req,
    input  logic             i_l_rnw,
    input  logic [WIDTH-1:0] i_l_addr,
    input  logic [WIDTH-1:0] i_l_wdata,
    output logic             o_l_gnt,
    output logic             o_l_rvalid,
    output logic [WIDTH-1:0] o_l_rdata,
    output logic             o_mem_rq,
    output logic             o_rnw,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_data,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
    localparam logic [7:0] SMAX = 8'(STARVE_MAX);
    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       run, starved, l_rd;
    always_comb begin
        run      = state == RUN;
        starved  = cnt == SMAX;
        // RUN and HALT share one rule: halt level alone selects the phase
        state_nx = state == BOOT ? (i_boot_done ? (i_halt ? HALT : RUN) : BOOT) :
                   (state == RUN || state == HALT) ? (i_halt ? HALT : RUN) : BOOT;
        o_l_gnt  = i_l_req & (!run | !i_f_req | starved);
        o_f_gnt  = run & i_f_req & !o_l_gnt;
        l_rd     = o_l_gnt & i_l_rnw;
        o_mem_rq = o_f_gnt | o_l_gnt;
        o_rnw    = o_l_gnt ? i_l_rnw : 1'b1;
        o_pc     = o_f_gnt ? i_f_addr : o_l_gnt ? i_l_addr : '0;
        o_data   = o_l_gnt ? i_l_wdata : '0;
        cnt_nx   = (!run || state_nx != state || !i_l_req || o_l_gnt) ? 8'd0 :
                   starved ? cnt : cnt + 8'd1;
        o_state  = state;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= BOOT;
            cnt        <= '0;
            o_f_rvalid <= 1'b0;
            o_l_rvalid <= 1'b0;
            o_f_rdata  <= '0;
            o_l_rdata  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            o_f_rvalid <= o_f_gnt;
            o_l_rvalid <= l_rd;
            if (o_f_gnt) o_f_rdata <= i_mem_data;
            if (l_rd) o_l_rdata <= i_mem_data;
        end
    end
endmodule
